// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift_seq engine: opcodes, FSM states and the
// predicate that tells single-shot commands apart from multi-step ones.
package shift_seq_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_CLR  = 4'd0;
    localparam logic [OP_W-1:0] OP_SET  = 4'd1;
    localparam logic [OP_W-1:0] OP_LSR  = 4'd2;
    localparam logic [OP_W-1:0] OP_LSL  = 4'd3;
    localparam logic [OP_W-1:0] OP_ASR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SIN  = 4'd5;
    localparam logic [OP_W-1:0] OP_ROR  = 4'd6;
    localparam logic [OP_W-1:0] OP_ROL  = 4'd7;
    localparam logic [OP_W-1:0] OP_LOAD = 4'd8;
    localparam logic [OP_W-1:0] OP_LFSR = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Reserved opcodes count as single-shot: one no-op step, amount ignored.
    function automatic logic is_single_shot(input logic [OP_W-1:0] op);
        logic single_s;
        case (op)
            OP_LSR, OP_LSL, OP_ASR, OP_SIN,
            OP_ROR, OP_ROL, OP_LFSR: single_s = 1'b0;
            default:                 single_s = 1'b1;
        endcase
        return single_s;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational next value of the data register for a single step of the
// latched operation.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic [WIDTH-1:0] d_o
);

    // One-bit step selected by the opcode; reserved codes hold the value.
    always_comb begin
        d_o = d_i;
        case (op_i)
            OP_CLR:  d_o = {WIDTH{1'b0}};
            OP_SET:  d_o = {{(WIDTH-1){1'b0}}, 1'b1};
            OP_LSR:  d_o = {1'b0, d_i[WIDTH-1:1]};
            OP_LSL:  d_o = {d_i[WIDTH-2:0], 1'b0};
            OP_ASR:  d_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            OP_SIN:  d_o = {ser_i, d_i[WIDTH-1:1]};
            OP_ROR:  d_o = {d_i[0], d_i[WIDTH-1:1]};
            OP_ROL:  d_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            OP_LOAD: d_o = cmd_data_i;
            OP_LFSR: d_o = {^(d_i & TAPS), d_i[WIDTH-1:1]};
            default: d_o = d_i;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Command-driven shift/rotate engine: accepts one command, performs its steps
// at the prescaled rate and pulses done alongside the final result.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               AMT_W = 4,
    parameter int               DIV   = 1,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy,
    output logic             done
);

    localparam int               PRE_W    = $clog2(DIV + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] load_q;
    logic [AMT_W-1:0] rem_q;
    logic [PRE_W-1:0] pre_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    shift_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .op_i       (op_q),
        .d_i        (data_q),
        .ser_i      (ser_i),
        .cmd_data_i (load_q),
        .d_o        (data_d)
    );

    // Control FSM with prescaler, remaining-step counter and data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLR;
            load_q  <= {WIDTH{1'b0}};
            rem_q   <= {AMT_W{1'b0}};
            pre_q   <= {PRE_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        load_q  <= cmd_data;
                        rem_q   <= is_single_shot(cmd_op) ? AMT_W'(1) : cmd_amt;
                        pre_q   <= {PRE_W{1'b0}};
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A zero-step command finishes on the first RUN edge.
                    if (rem_q == {AMT_W{1'b0}}) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (pre_q == PRE_LAST) begin
                        data_q <= data_d;
                        pre_q  <= {PRE_W{1'b0}};
                        rem_q  <= rem_q - AMT_W'(1);
                        if (rem_q == AMT_W'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign data_o    = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Randomised and directed bench for shift_seq at DIV=1 and DIV=4, checked
// cycle by cycle against a closed-form reference of the step rules.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_a [2];
    logic       ready_a [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic [7:0] data_a  [2];
    logic [3:0] cmd_op;
    logic [3:0] cmd_amt;
    logic [7:0] cmd_data;
    logic       ser_i;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_data [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shift_seq #(
            .WIDTH (8),
            .AMT_W (4),
            .DIV   ((g == 0) ? 1 : 4),
            .TAPS  (8'hB8)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (valid_a[g]),
            .cmd_ready (ready_a[g]),
            .cmd_op    (cmd_op),
            .cmd_amt   (cmd_amt),
            .cmd_data  (cmd_data),
            .ser_i     (ser_i),
            .data_o    (data_a[g]),
            .busy      (busy_a[g]),
            .done      (done_a[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_single(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd8) || (op >= 4'd10);
    endfunction

    // Register value after n steps of op from d; sv holds serial bits, first step in bit 0.
    function automatic logic [7:0] ref_val(input logic [3:0] op, input int n, input logic [7:0] d,
                                           input logic [7:0] ld, input int sv);
        logic [15:0] dd;
        logic [7:0]  x;
        int          r;
        int          w;
        if (n == 0) return d;
        dd = {d, d};
        r  = n % 8;
        case (op)
            4'd0: return 8'h00;
            4'd1: return 8'h01;
            4'd2: return (n >= 8) ? 8'h00 : 8'(d >> n);
            4'd3: return (n >= 8) ? 8'h00 : 8'(d << n);
            4'd4: return (n >= 8) ? {8{d[7]}} : 8'($signed(d) >>> n);
            4'd5: begin
                w = (sv << 8) | int'(d);
                return 8'(w >> n);
            end
            4'd6: return 8'(dd >> r);
            4'd7: begin
                dd = dd << r;
                return dd[15:8];
            end
            4'd8: return ld;
            4'd9: begin
                x = d;
                repeat (n) x = {^(x & 8'hB8), x[7:1]};
                return x;
            end
            default: return d;
        endcase
    endfunction

    // Issue one command at a negedge and check every cycle up to the done cycle.
    task automatic run_cmd(input int u, input logic [3:0] op, input int amt, input logic [7:0] ld,
                           input int pat, input bit use_pat, input int exp_final);
        int         div;
        int         n_steps;
        int         lat;
        int         sv;
        int         n;
        logic       s;
        logic [7:0] start;
        div     = (u == 0) ? 1 : 4;
        n_steps = is_single(op) ? 1 : amt;
        lat     = (n_steps == 0) ? 1 : n_steps * div;
        start   = m_data[u];
        sv      = 0;
        check_eq("ready_before", ready_a[u], 32'd1);
        cmd_op     = op;
        cmd_amt    = 4'(amt);
        cmd_data   = ld;
        valid_a[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= lat; c++) begin
            if (use_pat && (c % div == 0) && (c / div <= n_steps)) s = pat[c/div-1];
            else s = 1'($urandom);
            ser_i = s;
            if ((c % div == 0) && (c / div <= n_steps)) sv |= int'(s) << (c / div - 1);
            valid_a[u] = 1'($urandom);
            cmd_op     = 4'($urandom);
            cmd_amt    = 4'($urandom);
            cmd_data   = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            n = c / div;
            if (n > n_steps) n = n_steps;
            check_eq("data", data_a[u], ref_val(op, n, start, ld, sv));
            check_eq("done", done_a[u], (c == lat) ? 32'd1 : 32'd0);
            check_eq("busy", busy_a[u], (c == lat) ? 32'd0 : 32'd1);
        end
        valid_a[u] = 1'b0;
        check_eq("ready_done", ready_a[u], 32'd1);
        m_data[u] = ref_val(op, n_steps, start, ld, sv);
        if (exp_final >= 0) check_eq("final", data_a[u], exp_final);
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_a[0] = 1'b0;
        valid_a[1] = 1'b0;
        cmd_op     = 4'd0;
        cmd_amt    = 4'd0;
        cmd_data   = 8'd0;
        ser_i      = 1'b0;
        m_data[0]  = 8'd0;
        m_data[1]  = 8'd0;
        #12;
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_data", data_a[u], 32'd0);
            check_eq("rst_busy", busy_a[u], 32'd0);
            check_eq("rst_done", done_a[u], 32'd0);
            check_eq("rst_ready", ready_a[u], 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // DIV=1 directed sequence
        run_cmd(0, 4'd8, 0, 8'hA5, 0, 1'b0, 8'hA5);
        run_cmd(0, 4'd7, 3, 8'h00, 0, 1'b0, 8'h2D);
        run_cmd(0, 4'd8, 0, 8'h80, 0, 1'b0, 8'h80);
        run_cmd(0, 4'd4, 3, 8'h00, 0, 1'b0, 8'hF0);
        run_cmd(0, 4'd2, 9, 8'h00, 0, 1'b0, 8'h00);
        run_cmd(0, 4'd6, 0, 8'h00, 0, 1'b0, 8'h00);
        run_cmd(0, 4'd0, 0, 8'h00, 0, 1'b0, 8'h00);
        run_cmd(0, 4'd5, 8, 8'h00, 32'h4D, 1'b1, 8'h4D);
        run_cmd(0, 4'd8, 0, 8'h80, 0, 1'b0, 8'h80);
        run_cmd(0, 4'd9, 1, 8'h00, 0, 1'b0, 8'hC0);
        run_cmd(0, 4'd8, 0, 8'h00, 0, 1'b0, 8'h00);
        run_cmd(0, 4'd9, 5, 8'h00, 0, 1'b0, 8'h00);
        run_cmd(0, 4'd8, 0, 8'h3C, 0, 1'b0, 8'h3C);
        run_cmd(0, 4'd12, 7, 8'hFF, 0, 1'b0, 8'h3C);

        // DIV=4 directed sequence, then an idle cycle to see done drop
        run_cmd(1, 4'd1, 0, 8'h00, 0, 1'b0, 8'h01);
        run_cmd(1, 4'd3, 2, 8'h00, 0, 1'b0, 8'h04);
        @(posedge clk);
        @(negedge clk);
        check_eq("done_one_cycle", done_a[1], 32'd0);
        run_cmd(1, 4'd6, 0, 8'h00, 0, 1'b0, 8'h04);
        run_cmd(1, 4'd5, 3, 8'h00, 32'h5, 1'b1, 8'hA0);

        for (int i = 0; i < 60; i++) begin
            run_cmd(int'($urandom_range(0, 1)), 4'($urandom), int'($urandom_range(0, 15)),
                    8'($urandom), 0, 1'b0, -1);
        end

        // Reset in the middle of a DIV=4 command
        run_cmd(1, 4'd8, 0, 8'h11, 0, 1'b0, 8'h11);
        cmd_op     = 4'd3;
        cmd_amt    = 4'd5;
        valid_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a[1] = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_busy", busy_a[1], 32'd1);
        check_eq("pre_rst_data", data_a[1], 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_data", data_a[1], 32'd0);
        check_eq("async_rst_busy", busy_a[1], 32'd0);
        check_eq("async_rst_ready", ready_a[1], 32'd1);
        check_eq("async_rst_data0", data_a[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_eq("post_rst_done", done_a[1], 32'd0);
            check_eq("post_rst_busy", busy_a[1], 32'd0);
        end
        m_data[0] = 8'd0;
        m_data[1] = 8'd0;
        run_cmd(1, 4'd1, 0, 8'h00, 0, 1'b0, 8'h01);
        run_cmd(0, 4'd7, 9, 8'h00, 0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
